// File: rtl/prefix_add_pkg.sv
// Shared constants for the prefix_add arithmetic block.
package prefix_add_pkg;

  // Operand width used when the instantiating code does not override WIDTH.
  localparam int unsigned PA_DEFAULT_WIDTH = 8;

endpackage : prefix_add_pkg

// File: rtl/prefix_add_cell.sv
// Kogge-Stone black cell: combines the (G,P) pair of a higher-order group
// with the (G,P) pair of the adjacent lower-order group.
module prefix_cell (
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic go,
  output logic po
);

  // (G,P) o (G',P') = (G | P&G', P&P')
  always_comb begin
    go = gi | (pi & gj);
    po = pi & pj;
  end

endmodule : prefix_cell

// File: rtl/prefix_add.sv
// Registered WIDTH-bit Kogge-Stone adder: {cout,S} = a + b + cin, one cycle
// latency, a new operand set accepted every clock.
module prefix_add
  import prefix_add_pkg::*;
#(
  parameter int unsigned WIDTH = PA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] gf;
  logic [WIDTH-1:0] p_all_unused;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Per-bit generate/propagate, with cin folded into the bit-0 generate so
  // the tree yields carries that already include the carry-in.
  always_comb begin
    p0    = a ^ b;
    g0    = a & b;
    g0[0] = (a[0] & b[0]) | (p0[0] & cin);
  end

  // log2(WIDTH) levels; level lv combines each node with the one 2**lv below.
  for (genvar lv = 0; lv < LEVELS; lv++) begin : stage
    localparam int unsigned SPAN = 1 << lv;
    logic [WIDTH-1:0] gin;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] gout;
    logic [WIDTH-1:0] pout;

    if (lv == 0) begin : src0
      assign gin = g0;
      assign pin = p0;
    end else begin : srcn
      assign gin = stage[lv-1].gout;
      assign pin = stage[lv-1].pout;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : node
      if (i >= SPAN) begin : black
        prefix_cell u_cell (
          .gi (gin[i]),
          .pi (pin[i]),
          .gj (gin[i-SPAN]),
          .pj (pin[i-SPAN]),
          .go (gout[i]),
          .po (pout[i])
        );
      end else begin : buffer
        assign gout[i] = gin[i];
        assign pout[i] = pin[i];
      end
    end
  end

  assign gf = stage[LEVELS-1].gout;
  // Whole-group propagate out of the final level has no consumer.
  assign p_all_unused = stage[LEVELS-1].pout;

  // Carry into bit i is the group generate of bits [i-1:0]; bit 0 takes cin.
  always_comb begin
    sum_d  = p0 ^ {gf[WIDTH-2:0], cin};
    cout_d = gf[WIDTH-1];
  end

  // Result register; reset clears it asynchronously, dropping any pending sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign S    = sum_q;
  assign cout = cout_q;

endmodule : prefix_add

// File: tb/tb_prefix_add.sv
// Self-checking bench for prefix_add at WIDTH 8, 16 and 32.
module tb_prefix_add;

  logic        clk;
  logic        rst;

  logic [7:0]  a8, b8, s8;
  logic        cin8, co8;
  logic [15:0] a16, b16, s16;
  logic        cin16, co16;
  logic [31:0] a32, b32, s32;
  logic        cin32, co32;

  logic [8:0]  q8  [$];
  logic [16:0] q16 [$];
  logic [32:0] q32 [$];

  int unsigned checks;
  int unsigned failures;

  prefix_add #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .S(s8), .cout(co8)
  );
  prefix_add #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .S(s16), .cout(co16)
  );
  prefix_add #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .cin(cin32), .S(s32), .cout(co32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic no_result(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=no_expected_entry expected=queued_result", tag);
  endtask

  // Drive one WIDTH=8 operand set and queue its reference result.
  task automatic drive8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    logic [8:0] e;
    a8 = va; b8 = vb; cin8 = vc;
    e = {1'b0, va} + {1'b0, vb} + {8'd0, vc};
    q8.push_back(e);
  endtask

  task automatic check8(input string tag);
    logic [8:0] e;
    if (q8.size() == 0) no_result(tag);
    else begin
      e = q8.pop_front();
      chk(tag, {24'd0, co8, s8}, {24'd0, e});
    end
  endtask

  task automatic step8(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic vc);
    drive8(va, vb, vc);
    @(posedge clk); #1;
    check8(tag);
  endtask

  logic [7:0] da [10] = '{8'd0, 8'd100, 8'd20, 8'd33, 8'd100, 8'd90, 8'd177, 8'd90, 8'd24, 8'd0};
  logic [7:0] db [10] = '{8'd41, 8'd24, 8'd178, 8'd75, 8'd50, 8'd40, 8'd54, 8'd60, 8'd43, 8'd1};
  logic [7:0] ds [10] = '{8'd41, 8'd124, 8'd198, 8'd108, 8'd150, 8'd130, 8'd231, 8'd150, 8'd67, 8'd1};

  initial begin
    logic [15:0] r16a, r16b;
    logic [31:0] r32a, r32b;
    logic        rc;
    logic [16:0] e16;
    logic [32:0] e32;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;
    a32 = '0; b32 = '0; cin32 = 1'b0;

    // Before any reset: a plain sum so the reset below has something to clear.
    step8("pre_reset", 8'hFF, 8'h01, 1'b1);

    // Asynchronous reset between edges.
    #2;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async", {24'd0, co8, s8}, 33'd0);
    chk("rst_async16", {16'd0, co16, s16}, 33'd0);
    chk("rst_async32", {co32, s32}, 33'd0);
    @(posedge clk); #1;
    chk("rst_hold", {24'd0, co8, s8}, 33'd0);
    rst = 1'b0;
    step8("post_reset", 8'hFF, 8'h01, 1'b0);
    chk("post_reset_const", {24'd0, co8, s8}, {24'd0, 1'b1, 8'h00});

    // Directed sums, cin = 0; also compare against the hand-computed sums.
    for (int i = 0; i < 10; i++) begin
      step8("directed", da[i], db[i], 1'b0);
      chk("directed_const", {24'd0, co8, s8}, {24'd0, 1'b0, ds[i]});
    end

    // Full carry propagation and boundary sums.
    step8("chain_ff_cin", 8'hFF, 8'h00, 1'b1);
    chk("chain_ff_cin_const", {24'd0, co8, s8}, {24'd0, 1'b1, 8'h00});
    step8("chain_7f_01", 8'h7F, 8'h01, 1'b0);
    chk("chain_7f_01_const", {24'd0, co8, s8}, {24'd0, 1'b0, 8'h80});
    step8("max_ff_ff", 8'hFF, 8'hFF, 1'b1);
    chk("max_ff_ff_const", {24'd0, co8, s8}, {24'd0, 1'b1, 8'hFF});
    step8("wrap_80_80", 8'h80, 8'h80, 1'b0);
    chk("wrap_80_80_const", {24'd0, co8, s8}, {24'd0, 1'b1, 8'h00});

    // Back-to-back: a new operand set every cycle, each result one edge later.
    for (int i = 0; i < 16; i++)
      step8("throughput", 8'($urandom), 8'($urandom), 1'($urandom));

    // Mid-stream reset: pending result is dropped, outputs clear before the edge.
    drive8(8'hC3, 8'h5A, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_async", {24'd0, co8, s8}, 33'd0);
    q8.delete();
    #1;
    rst = 1'b0;
    step8("midrst_first", 8'h3C, 8'hA5, 1'b1);
    step8("midrst_next", 8'hF0, 8'h0F, 1'b1);

    // Random vectors on all three widths simultaneously.
    for (int n = 0; n < 10000; n++) begin
      r16a = 16'($urandom); r16b = 16'($urandom);
      r32a = $urandom;      r32b = $urandom;
      rc   = 1'($urandom);
      drive8(8'($urandom), 8'($urandom), 1'($urandom));
      a16 = r16a; b16 = r16b; cin16 = rc;
      a32 = r32a; b32 = r32b; cin32 = ~rc;
      q16.push_back({1'b0, r16a} + {1'b0, r16b} + {16'd0, rc});
      q32.push_back({1'b0, r32a} + {1'b0, r32b} + {32'd0, ~rc});
      @(posedge clk); #1;
      check8("rand8");
      if (q16.size() == 0) no_result("rand16");
      else begin
        e16 = q16.pop_front();
        chk("rand16", {16'd0, co16, s16}, {16'd0, e16});
      end
      if (q32.size() == 0) no_result("rand32");
      else begin
        e32 = q32.pop_front();
        chk("rand32", {co32, s32}, e32);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prefix_add
